// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared state encodings, source ids and timeout data for imem_arb
package imem_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;
  localparam logic SRC_FETCH = 1'b0;
  localparam logic SRC_LSU = 1'b1;
  localparam logic [31:0] TMO_DATA = 32'h0;
endpackage

// File: rtl/imem_tmo.sv
// imem_tmo: transaction timeout counter, hit pulses on the TMO_CYC-th enabled cycle
// ports: clk, rst_n (sync, active-low), clr (restart count), en (count this cycle), hit (limit reached)
module imem_tmo #(
  parameter int TMO_CYC = 255,
  parameter int TMO_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);
  logic [TMO_W-1:0] cnt;
  // Saturating at the limit keeps hit asserted if the arbiter stays in REQ/WAIT past it.
  assign hit = en && cnt == TMO_W'(TMO_CYC - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !hit) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/imem_arb.sv
// imem_arb: round-robin arbiter of fetch and LSU reads onto one instruction-memory port
// ports: i_Clk/i_RstN clock and sync active-low reset; i_Fetch*/o_Fetch* fetch side;
// i_Lsu*/o_Lsu* LSU side; i_Flush jump redirect; o_Mem*/i_Mem* memory port; o_Err sticky timeout
module imem_arb
  import imem_arb_pkg::*;
#(
  parameter int TMO_CYC = 255,
  parameter int TMO_W = 8
) (
  input  logic        i_Clk,
  input  logic        i_RstN,
  input  logic        i_FetchV,
  input  logic [31:0] i_FetchT,
  output logic        o_FetchTrgtV,
  output logic [31:0] o_FetchD,
  input  logic        i_LsuV,
  input  logic [31:0] i_LsuA,
  output logic        o_LsuTrgtV,
  output logic [31:0] o_LsuD,
  input  logic        i_Flush,
  output logic        o_MemV,
  output logic [31:0] o_MemA,
  output logic        o_MemSrc,
  input  logic        i_MemAck,
  input  logic        i_MemRspV,
  input  logic [31:0] i_MemRspD,
  output logic        o_Err
);
  state_t state, state_nx;
  logic src, last, drop, err, hit, req_any, gnt_src, rsp_take, tmo_fire;
  logic [31:0] mem_a, fetch_d, lsu_d;
  imem_tmo #(.TMO_CYC(TMO_CYC), .TMO_W(TMO_W)) u_tmo (
    .clk  (i_Clk),
    .rst_n(i_RstN),
    .clr  (state == ST_IDLE),
    .en   (state == ST_REQ || state == ST_WAIT),
    .hit  (hit)
  );
  assign req_any = i_FetchV | i_LsuV;
  // On a tie the requester not granted last wins; otherwise the lone requester.
  assign gnt_src = (i_FetchV & i_LsuV) ? ~last : i_LsuV;
  assign rsp_take = state == ST_WAIT && i_MemRspV;
  // The awaited memory event wins over a timeout landing in the same cycle.
  assign tmo_fire = hit && !(state == ST_REQ ? i_MemAck : i_MemRspV);
  always_ff @(posedge i_Clk) begin
    if (!i_RstN) state <= ST_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == ST_IDLE ? (req_any ? ST_REQ : ST_IDLE)
             : state == ST_REQ  ? (i_MemAck ? ST_WAIT : hit ? ST_RESP : ST_REQ)
             : state == ST_WAIT ? ((i_MemRspV || hit) ? ST_RESP : ST_WAIT)
             : ST_IDLE;
  end
  always_comb begin
    o_MemV = state == ST_REQ;
    o_FetchTrgtV = state == ST_RESP && src == SRC_FETCH && !drop && !i_Flush;
    o_LsuTrgtV = state == ST_RESP && src == SRC_LSU;
  end
  always_ff @(posedge i_Clk) begin
    if (!i_RstN) begin
      src <= SRC_FETCH;
      last <= SRC_LSU;
      mem_a <= '0;
      fetch_d <= '0;
      lsu_d <= '0;
      drop <= 1'b0;
      err <= 1'b0;
    end else begin
      if (state == ST_IDLE && req_any) begin
        src <= gnt_src;
        last <= gnt_src;
        mem_a <= gnt_src ? i_LsuA : i_FetchT;
      end
      if ((rsp_take || tmo_fire) && src == SRC_LSU) lsu_d <= rsp_take ? i_MemRspD : TMO_DATA;
      if ((rsp_take || tmo_fire) && src == SRC_FETCH) fetch_d <= rsp_take ? i_MemRspD : TMO_DATA;
      if (tmo_fire) err <= 1'b1;
      drop <= state_nx == ST_IDLE ? 1'b0
            : drop | (i_Flush && state != ST_IDLE && src == SRC_FETCH);
    end
  end
  assign o_MemA = mem_a;
  assign o_MemSrc = src;
  assign o_FetchD = fetch_d;
  assign o_LsuD = lsu_d;
  assign o_Err = err;
endmodule

// File: tb/tb_imem_arb.sv
// tb_imem_arb: randomized self-checking bench for imem_arb against a transaction-level model
module tb_imem_arb;
  localparam int TMO = 4;
  logic i_Clk, i_RstN, i_FetchV, i_LsuV, i_Flush, i_MemAck, i_MemRspV;
  logic [31:0] i_FetchT, i_LsuA, i_MemRspD;
  logic o_FetchTrgtV, o_LsuTrgtV, o_MemV, o_MemSrc, o_Err;
  logic [31:0] o_FetchD, o_LsuD, o_MemA;
  int n_chk = 0;
  int n_pass = 0;
  logic last_m, err_m;
  typedef struct {
    logic src;
    logic [31:0] addr;
    int memv, fp, lp, pc;
    logic [31:0] d;
    logic err;
  } txn_t;

  imem_arb #(.TMO_CYC(TMO), .TMO_W(8)) dut (
    .i_Clk(i_Clk), .i_RstN(i_RstN),
    .i_FetchV(i_FetchV), .i_FetchT(i_FetchT), .o_FetchTrgtV(o_FetchTrgtV), .o_FetchD(o_FetchD),
    .i_LsuV(i_LsuV), .i_LsuA(i_LsuA), .o_LsuTrgtV(o_LsuTrgtV), .o_LsuD(o_LsuD),
    .i_Flush(i_Flush), .o_MemV(o_MemV), .o_MemA(o_MemA), .o_MemSrc(o_MemSrc),
    .i_MemAck(i_MemAck), .i_MemRspV(i_MemRspV), .i_MemRspD(i_MemRspD), .o_Err(o_Err)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Transaction-level reference: who wins, how many cycles it occupies, what it returns.
  task automatic model_txn(input logic fv, lv, input logic [31:0] fa, la, input int a_del, r_del,
                           flush_c, input logic [31:0] rd, output txn_t e, output int win);
    int k_ack, k_end;
    logic tmo, dropped;
    e.src = (fv && lv) ? !last_m : lv;
    last_m = e.src;
    e.addr = e.src ? la : fa;
    k_ack = 0; k_end = 0; tmo = 1'b0;
    for (int k = 1; k < 64 && k_end == 0; k++) begin
      if (k_ack == 0 && k == a_del + 1) k_ack = k;
      else if (k_ack != 0 && k == k_ack + r_del) k_end = k;
      else if (k >= TMO) begin k_end = k; tmo = 1'b1; end
    end
    e.memv = k_ack != 0 ? k_ack : k_end;
    e.pc = k_end + 1;
    e.d = tmo ? 32'h0 : rd;
    dropped = !e.src && flush_c >= 1 && flush_c <= k_end + 1;
    e.fp = (!e.src && !dropped) ? 1 : 0;
    e.lp = e.src ? 1 : 0;
    err_m = err_m | tmo;
    e.err = err_m;
    win = k_end + 1;
  endtask

  // Requesters plus a memory that acks a_del cycles into REQ and answers r_del cycles after ack.
  task automatic run_txn(input logic fv, lv, input logic [31:0] fa, la, input int a_del, r_del,
                         flush_c, input logic [31:0] rd, input int win, output txn_t o);
    int seen, ack_c;
    o = '{src: 1'b0, addr: 32'h0, memv: 0, fp: 0, lp: 0, pc: 0, d: 32'h0, err: 1'b0};
    i_FetchV = fv; i_LsuV = lv; i_FetchT = fa; i_LsuA = la;
    i_MemAck = 1'b0; i_MemRspV = 1'b0; i_Flush = flush_c == 0;
    seen = 0; ack_c = -1;
    for (int c = 1; c <= win; c++) begin
      @(negedge i_Clk);
      i_MemAck = 1'b0; i_MemRspV = 1'b0;
      if (o_MemV) begin
        seen++;
        o.memv++;
        if (c == 1) begin o.src = o_MemSrc; o.addr = o_MemA; end
        if (seen == a_del + 1 && ack_c < 0) begin i_MemAck = 1'b1; ack_c = c; end
      end
      if (ack_c > 0 && c == ack_c + r_del) begin i_MemRspV = 1'b1; i_MemRspD = rd; end
      i_Flush = c == flush_c;
      #1;
      if (o_FetchTrgtV) begin o.fp++; o.d = o_FetchD; o.pc = c; end
      if (o_LsuTrgtV) begin o.lp++; o.d = o_LsuD; o.pc = c; end
    end
    o.err = o_Err;
    @(negedge i_Clk);
    i_Flush = 1'b0; i_MemAck = 1'b0; i_MemRspV = 1'b0;
  endtask

  task automatic do_reset();
    i_RstN = 1'b0; i_FetchV = 1'b0; i_LsuV = 1'b0; i_Flush = 1'b0;
    i_MemAck = 1'b0; i_MemRspV = 1'b0; i_FetchT = 32'h0; i_LsuA = 32'h0; i_MemRspD = 32'h0;
    repeat (2) @(negedge i_Clk);
    i_RstN = 1'b1;
    last_m = 1'b1;
    err_m = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_chk++;
    if ({o_MemV, o_MemA, o_MemSrc, o_FetchTrgtV, o_LsuTrgtV, o_Err} !== 36'h0)
      $display("FAIL reset_ctl got %h exp 0", {o_MemV, o_MemA, o_MemSrc, o_FetchTrgtV, o_LsuTrgtV, o_Err});
    else n_pass++;
    n_chk++;
    if ({o_FetchD, o_LsuD} !== 64'h0) $display("FAIL reset_data got %h exp 0", {o_FetchD, o_LsuD});
    else n_pass++;
  endtask

  task automatic test_single_fetch();
    txn_t e, o;
    int win;
    model_txn(1'b1, 1'b0, 32'h100, 32'h0, 0, 1, 99, 32'hA5A5_0001, e, win);
    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 0, 1, 99, 32'hA5A5_0001, win, o);
    n_chk++;
    if ({o.src, o.addr} !== {1'b0, 32'h100}) $display("FAIL single_req got %h exp %h", {o.src, o.addr}, {1'b0, 32'h100});
    else n_pass++;
    n_chk++;
    if (o.fp !== 1 || o.lp !== 0 || o.pc !== 3) $display("FAIL single_pulse got fp=%0d lp=%0d cyc=%0d exp 1 0 3", o.fp, o.lp, o.pc);
    else n_pass++;
    n_chk++;
    if (o.d !== 32'hA5A5_0001) $display("FAIL single_data got %h exp %h", o.d, 32'hA5A5_0001);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    txn_t e, o;
    int win, a, r;
    logic [31:0] rd;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = $urandom_range(0, 2); r = $urandom_range(1, 2); rd = $urandom;
      model_txn(1'b1, 1'b1, 32'h1000 + i * 4, 32'h2000 + i * 4, a, r, 99, rd, e, win);
      run_txn(1'b1, 1'b1, 32'h1000 + i * 4, 32'h2000 + i * 4, a, r, 99, rd, win, o);
      n_chk++;
      if (o.src !== 1'(i % 2)) $display("FAIL rr_grant%0d got %0d exp %0d", i, o.src, i % 2);
      else n_pass++;
      n_chk++;
      if (o.fp + o.lp !== 1 || o.lp !== i % 2) $display("FAIL rr_pulse%0d got fp=%0d lp=%0d exp lp=%0d", i, o.fp, o.lp, i % 2);
      else n_pass++;
      n_chk++;
      if (o.d !== e.d) $display("FAIL rr_data%0d got %h exp %h", i, o.d, e.d);
      else n_pass++;
    end
  endtask

  task automatic test_flush_wait();
    txn_t e, o;
    int win;
    model_txn(1'b1, 1'b0, 32'h300, 32'h0, 0, 3, 2, 32'h1234_5678, e, win);
    run_txn(1'b1, 1'b0, 32'h300, 32'h0, 0, 3, 2, 32'h1234_5678, win, o);
    n_chk++;
    if (o.fp !== 0 || o.lp !== 0 || o.memv !== 1) $display("FAIL flush_drop got fp=%0d lp=%0d memv=%0d exp 0 0 1", o.fp, o.lp, o.memv);
    else n_pass++;
    model_txn(1'b1, 1'b0, 32'h200, 32'h0, 1, 1, 99, 32'hCAFE_0200, e, win);
    run_txn(1'b1, 1'b0, 32'h200, 32'h0, 1, 1, 99, 32'hCAFE_0200, win, o);
    n_chk++;
    if (o.addr !== 32'h200 || o.fp !== 1 || o.pc !== 4) $display("FAIL flush_next got addr=%h fp=%0d cyc=%0d exp 200 1 4", o.addr, o.fp, o.pc);
    else n_pass++;
    n_chk++;
    if (o.d !== 32'hCAFE_0200) $display("FAIL flush_next_data got %h exp %h", o.d, 32'hCAFE_0200);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    txn_t e, o;
    int win;
    logic [31:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 32'h4000 + i * 16;
      model_txn(i % 2 == 0, i % 2 == 1, a, a, 0, 1, 99, ~a, e, win);
      run_txn(i % 2 == 0, i % 2 == 1, a, a, 0, 1, 99, ~a, win, o);
      n_chk++;
      if (o.addr !== a || o.memv !== 1 || o.pc !== 3 || o.d !== ~a)
        $display("FAIL b2b%0d got addr=%h memv=%0d cyc=%0d d=%h exp %h 1 3 %h", i, o.addr, o.memv, o.pc, o.d, a, ~a);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    txn_t e, o;
    int win, a, r, f, sel;
    logic [31:0] fa, la, rd;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(1, 3); a = $urandom_range(0, 5); r = $urandom_range(1, 3);
      f = $urandom_range(0, 8); fa = $urandom; la = $urandom; rd = $urandom;
      model_txn(sel[0], sel[1], fa, la, a, r, f, rd, e, win);
      run_txn(sel[0], sel[1], fa, la, a, r, f, rd, win, o);
      n_chk++;
      if (o.src !== e.src || o.addr !== e.addr || o.memv !== e.memv)
        $display("FAIL rnd%0d_req got src=%0d addr=%h memv=%0d exp %0d %h %0d", i, o.src, o.addr, o.memv, e.src, e.addr, e.memv);
      else n_pass++;
      n_chk++;
      if (o.fp !== e.fp || o.lp !== e.lp) $display("FAIL rnd%0d_pulse got fp=%0d lp=%0d exp %0d %0d", i, o.fp, o.lp, e.fp, e.lp);
      else n_pass++;
      if (e.fp + e.lp == 1) begin
        n_chk++;
        if (o.pc !== e.pc || o.d !== e.d) $display("FAIL rnd%0d_rsp got cyc=%0d d=%h exp %0d %h", i, o.pc, o.d, e.pc, e.d);
        else n_pass++;
      end
      n_chk++;
      if (o.err !== e.err) $display("FAIL rnd%0d_err got %b exp %b", i, o.err, e.err);
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    txn_t e, o;
    int win;
    do_reset();
    model_txn(1'b0, 1'b1, 32'h0, 32'h400, 100, 1, 99, 32'h5555_5555, e, win);
    run_txn(1'b0, 1'b1, 32'h0, 32'h400, 100, 1, 99, 32'h5555_5555, win, o);
    n_chk++;
    if (o.lp !== 1 || o.d !== 32'h0 || o.pc !== 5 || o.memv !== 4)
      $display("FAIL tmo_rsp got lp=%0d d=%h cyc=%0d memv=%0d exp 1 0 5 4", o.lp, o.d, o.pc, o.memv);
    else n_pass++;
    n_chk++;
    if (o.err !== 1'b1) $display("FAIL tmo_err got %b exp 1", o.err);
    else n_pass++;
    i_FetchV = 1'b0; i_LsuV = 1'b0; i_MemRspV = 1'b1; i_MemRspD = 32'hDEAD_BEEF;
    #1;
    n_chk++;
    if ({o_FetchTrgtV, o_LsuTrgtV} !== 2'b00) $display("FAIL tmo_late_idle got %b exp 00", {o_FetchTrgtV, o_LsuTrgtV});
    else n_pass++;
    @(negedge i_Clk);
    i_MemRspV = 1'b0;
    #1;
    n_chk++;
    if ({o_MemV, o_FetchTrgtV, o_LsuTrgtV, o_Err, o_LsuD} !== {4'b0001, 32'h0})
      $display("FAIL tmo_late_after got %h exp %h", {o_MemV, o_FetchTrgtV, o_LsuTrgtV, o_Err, o_LsuD}, {4'b0001, 32'h0});
    else n_pass++;
    @(negedge i_Clk);
    model_txn(1'b0, 1'b1, 32'h0, 32'h404, 0, 1, 99, 32'h0BAD_F00D, e, win);
    run_txn(1'b0, 1'b1, 32'h0, 32'h404, 0, 1, 99, 32'h0BAD_F00D, win, o);
    n_chk++;
    if (o.err !== 1'b1 || o.d !== 32'h0BAD_F00D) $display("FAIL tmo_sticky got err=%b d=%h exp 1 %h", o.err, o.d, 32'h0BAD_F00D);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    i_FetchV = 1'b1; i_FetchT = 32'h800; i_LsuV = 1'b0;
    @(negedge i_Clk);
    i_MemAck = 1'b1;
    @(negedge i_Clk);
    i_MemAck = 1'b0; i_RstN = 1'b0;
    @(negedge i_Clk);
    i_RstN = 1'b1; i_FetchV = 1'b0; i_MemRspV = 1'b1; i_MemRspD = 32'h7777_7777;
    last_m = 1'b1; err_m = 1'b0;
    #1;
    n_chk++;
    if ({o_MemV, o_MemA, o_MemSrc, o_FetchTrgtV, o_LsuTrgtV, o_Err, o_FetchD, o_LsuD} !== 100'h0)
      $display("FAIL midrst_outs got %h exp 0", {o_MemV, o_MemA, o_MemSrc, o_FetchTrgtV, o_LsuTrgtV, o_Err, o_FetchD, o_LsuD});
    else n_pass++;
    @(negedge i_Clk);
    i_MemRspV = 1'b0;
    #1;
    n_chk++;
    if ({o_MemV, o_FetchTrgtV, o_LsuTrgtV} !== 3'b000) $display("FAIL midrst_late got %b exp 000", {o_MemV, o_FetchTrgtV, o_LsuTrgtV});
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_round_robin();
    test_flush_wait();
    test_back_to_back();
    test_random();
    test_timeout();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
